// File: rtl/conv1d_job_sequencer.sv
// rtl/conv1d_job_sequencer.sv - queues operand pairs and sequences a conv1d engine job per RUN command
module conv1d_job_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [6:0]  LOAD_CMD = 7'd1,
  parameter logic [6:0]  EXEC_CMD = 7'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        eng_en,
  output logic [6:0]  eng_cmd,
  output logic [31:0] eng_inp0,
  output logic [31:0] eng_inp1,
  input  logic [31:0] eng_ret,
  input  logic        eng_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OP_PUSH   = 7'h00;
  localparam logic [6:0] OP_RUN    = 7'h01;
  localparam logic [6:0] OP_STATUS = 7'h02;
  localparam logic [6:0] OP_FLUSH  = 7'h03;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [15:0] job_n_q, job_n_d, load_left_q, load_left_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] ret_q, ret_d;
  logic [6:0]  eng_cmd_q, eng_cmd_d;
  logic [31:0] eng_inp0_q, eng_inp0_d, eng_inp1_q, eng_inp1_d;
  logic [63:0] fifo_mem_q [DEPTH];
  logic        push_en;

  logic [6:0]  funct7;
  logic [15:0] run_n;
  logic        accept, fifo_full, run_err, wait_expired;
  logic [63:0] head;
  logic        unused_ok;

  assign funct7       = cmd_payload_function_id[9:3];
  assign run_n        = cmd_payload_inputs_0[15:0];
  assign accept       = cmd_valid && (state_q == S_IDLE);
  assign fifo_full    = (occ_q == CW'(DEPTH));
  assign run_err      = {16'b0, run_n} > 32'(occ_q);
  assign wait_expired = (wait_cnt_q == TW'(TIMEOUT - 1));
  assign head         = fifo_mem_q[rd_ptr_q];
  assign unused_ok    = ^cmd_payload_function_id[2:0];

  // State register, async reset aborts any job in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: FIFO pointers, job counters, response and held engine operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      job_n_q     <= '0;
      load_left_q <= '0;
      wait_cnt_q  <= '0;
      ret_q       <= '0;
      eng_cmd_q   <= '0;
      eng_inp0_q  <= '0;
      eng_inp1_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      job_n_q     <= job_n_d;
      load_left_q <= load_left_d;
      wait_cnt_q  <= wait_cnt_d;
      ret_q       <= ret_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_inp0_q  <= eng_inp0_d;
      eng_inp1_q  <= eng_inp1_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem_q[wr_ptr_q] <= {cmd_payload_inputs_0, cmd_payload_inputs_1};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (funct7 == OP_RUN) begin
            if (run_err)            state_d = S_RESP;
            else if (run_n == 16'd0) state_d = S_EXEC;
            else                     state_d = S_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_LOAD:  if (load_left_q == 16'd1) state_d = S_EXEC;
      S_EXEC:  state_d = S_WAIT;
      S_WAIT:  if (eng_valid || wait_expired) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; engine operands are presented live while strobing and held otherwise
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    job_n_d     = job_n_q;
    load_left_d = load_left_q;
    wait_cnt_d  = wait_cnt_q;
    ret_d       = ret_q;
    eng_cmd_d   = eng_cmd_q;
    eng_inp0_d  = eng_inp0_q;
    eng_inp1_d  = eng_inp1_q;
    push_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (funct7)
            OP_PUSH: begin
              if (!fifo_full) begin
                push_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                occ_d    = occ_q + CW'(1);
                ret_d    = 32'(occ_q) + 32'd1;
              end else begin
                ret_d = 32'hFFFF_FFFF;
              end
            end
            OP_RUN: begin
              job_n_d     = run_n;
              load_left_d = run_n;
              if (run_err) ret_d = 32'hFFFF_FFFE;
            end
            OP_STATUS: ret_d = 32'(occ_q);
            OP_FLUSH: begin
              ret_d    = 32'(occ_q);
              occ_d    = '0;
              rd_ptr_d = wr_ptr_q;
            end
            default: ret_d = 32'hFFFF_FFFD;
          endcase
        end
      end
      S_LOAD: begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        occ_d       = occ_q - CW'(1);
        load_left_d = load_left_q - 16'd1;
        eng_cmd_d   = LOAD_CMD;
        eng_inp0_d  = head[63:32];
        eng_inp1_d  = head[31:0];
      end
      S_EXEC: begin
        eng_cmd_d  = EXEC_CMD;
        eng_inp0_d = {16'b0, job_n_q};
        eng_inp1_d = '0;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (eng_valid)         ret_d = eng_ret;
        else if (wait_expired) ret_d = 32'hDEAD_0000 | {16'b0, job_n_q};
        else                   wait_cnt_d = wait_cnt_q + TW'(1);
      end
      default: ;
    endcase

    cmd_ready             = (state_q == S_IDLE);
    rsp_valid             = (state_q == S_RESP);
    rsp_payload_outputs_0 = ret_q;
    eng_en                = (state_q == S_LOAD) || (state_q == S_EXEC);
    eng_cmd               = eng_cmd_q;
    eng_inp0              = eng_inp0_q;
    eng_inp1              = eng_inp1_q;
    if (state_q == S_LOAD) begin
      eng_cmd  = LOAD_CMD;
      eng_inp0 = head[63:32];
      eng_inp1 = head[31:0];
    end else if (state_q == S_EXEC) begin
      eng_cmd  = EXEC_CMD;
      eng_inp0 = {16'b0, job_n_q};
      eng_inp1 = '0;
    end
  end
endmodule
